// File: rtl/serial_adder_16.sv
// Bit-serial adder: one full-add per clock, LSB first, with a valid/ready
// handshake on both the operand side and the result side.
module serial_adder_16 #(
  parameter int WIDTH = 16
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             In_Valid,
  output logic             In_Ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             Out_Valid,
  input  logic             Out_Ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Overflow
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t           state_reg, state_next;
  logic [CW-1:0]    cnt_reg;
  logic [WIDTH-1:0] a_reg, b_reg;
  logic [WIDTH-2:0] acc_reg;
  logic             carry_reg;
  logic [WIDTH-1:0] sum_reg;
  logic             cout_reg, ovf_reg;

  logic             sum_bit, carry_out, accept, last_bit;
  logic [WIDTH-1:0] acc_wide;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    In_Ready   = 1'b0;
    Out_Valid  = 1'b0;
    case (state_reg)
      IDLE: begin
        In_Ready = 1'b1;
        if (In_Valid) state_next = ADD;
      end
      ADD: begin
        if (cnt_reg == LAST) state_next = DONE;
      end
      DONE: begin
        Out_Valid = 1'b1;
        if (Out_Ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign accept    = (state_reg == IDLE) && In_Valid;
  assign last_bit  = (state_reg == ADD) && (cnt_reg == LAST);
  assign sum_bit   = a_reg[0] ^ b_reg[0] ^ carry_reg;
  assign carry_out = (a_reg[0] & b_reg[0]) | (carry_reg & (a_reg[0] ^ b_reg[0]));
  // New sum bit enters at the top; after WIDTH shifts the word is complete.
  assign acc_wide  = {sum_bit, acc_reg};

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      a_reg     <= '0;
      b_reg     <= '0;
      acc_reg   <= '0;
      carry_reg <= 1'b0;
      cnt_reg   <= '0;
      sum_reg   <= '0;
      cout_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
    end else if (accept) begin
      a_reg     <= A;
      b_reg     <= B;
      acc_reg   <= '0;
      carry_reg <= Cin;
      cnt_reg   <= '0;
    end else if (state_reg == ADD) begin
      a_reg     <= a_reg >> 1;
      b_reg     <= b_reg >> 1;
      acc_reg   <= acc_wide[WIDTH-1:1];
      carry_reg <= carry_out;
      if (last_bit) begin
        // carry_reg here is the carry into the MSB, so overflow needs no extra flop.
        sum_reg  <= acc_wide;
        cout_reg <= carry_out;
        ovf_reg  <= carry_reg ^ carry_out;
      end else begin
        cnt_reg <= cnt_reg + CW'(1);
      end
    end
  end

  assign Sum      = sum_reg;
  assign Cout     = cout_reg;
  assign Overflow = ovf_reg;

endmodule

// File: tb/tb_serial_adder_16.sv
// Randomized scoreboard bench for serial_adder_16: driver pushes expected
// results computed with plain arithmetic, a negedge monitor pops and compares.
module tb_serial_adder_16;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] sum;
  logic         cout;
  logic         overflow;

  serial_adder_16 #(.WIDTH(W)) dut (
    .Clk(clk), .Rst_n(rst_n),
    .In_Valid(in_valid), .In_Ready(in_ready),
    .A(a), .B(b), .Cin(cin),
    .Out_Valid(out_valid), .Out_Ready(out_ready),
    .Sum(sum), .Cout(cout), .Overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    int           cyc;
  } exp_t;

  exp_t q[$];
  exp_t held, last_e, mon_e;
  int   checks = 0;
  int   passes = 0;
  int   cycle = 0;
  logic prev_valid = 1'b0;
  logic prev_ready = 1'b0;

  always @(posedge clk) cycle <= cycle + 1;

  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    exp_t e;
    logic [W:0] t;
    t      = {1'b0, x} + {1'b0, y} + (W+1)'(c);
    e.sum  = t[W-1:0];
    e.cout = t[W];
    e.ovf  = (x[W-1] == y[W-1]) && (t[W-1] != x[W-1]);
    e.cyc  = 0;
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cycle);
  endtask

  // Monitor: one comparison set per result presented.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid <= 1'b0;
      prev_ready <= 1'b0;
    end else begin
      if (out_valid && !prev_valid) begin
        if (q.size() == 0) begin
          check("unexpected_result", 32'd1, 32'd0);
        end else begin
          mon_e = q.pop_front();
          check("sum", sum, mon_e.sum);
          check("cout", cout, mon_e.cout);
          check("overflow", overflow, mon_e.ovf);
          check("latency", cycle, mon_e.cyc);
          $display("result sum=%h cout=%b ovf=%b at cycle %0d", sum, cout, overflow, cycle);
        end
      end
      if (prev_valid && prev_ready) check("valid_one_cycle", out_valid, 32'd0);
      prev_valid <= out_valid;
      prev_ready <= out_ready;
    end
  end

  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic do_op(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xc,
                       output int acc_cyc);
    exp_t e;
    int n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("in_ready_timeout", 32'd0, 32'd1);
    a = xa; b = xb; cin = xc; in_valid = 1'b1;
    e = model(xa, xb, xc);
    acc_cyc = cycle + 1;
    e.cyc = acc_cyc + W;
    q.push_back(e);
    last_e = e;
    $display("issue A=%h B=%h Cin=%b expect sum=%h cout=%b ovf=%b", xa, xb, xc, e.sum, e.cout, e.ovf);
    @(negedge clk);
    in_valid = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    check("held_sum", sum, held.sum);
    check("held_cout", cout, held.cout);
    check("held_ovf", overflow, held.ovf);
    held = e;
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!out_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) check("out_valid_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_done();
    wait_valid();
    @(negedge clk);
  endtask

  initial begin
    int c1, c2, n;
    held = '{sum: '0, cout: 1'b0, ovf: 1'b0, cyc: 0};
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    do_op(16'h1234, 16'h4321, 1'b0, c1);
    wait_done();
    do_op(16'hFFFF, 16'h0001, 1'b0, c1);
    wait_done();
    do_op(16'h7FFF, 16'h0000, 1'b1, c1);
    wait_done();

    // Reset in the middle of bit 7, checked without any clock edge.
    do_op(16'h1111, 16'h2222, 1'b0, c1);
    repeat (7) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_in_ready", in_ready, 32'd1);
    check("rst_out_valid", out_valid, 32'd0);
    check("rst_sum", sum, 32'd0);
    check("rst_cout", cout, 32'd0);
    check("rst_ovf", overflow, 32'd0);
    q.delete();
    held = '{sum: '0, cout: 1'b0, ovf: 1'b0, cyc: 0};
    @(negedge clk);
    rst_n = 1'b1;
    do_op(16'h00FF, 16'h0001, 1'b1, c1);
    wait_done();

    // Backpressure with input noise while the result is held.
    out_ready = 1'b0;
    do_op(W'($urandom), W'($urandom), 1'($urandom), c1);
    wait_valid();
    for (int i = 0; i < 5; i++) begin
      a = W'($urandom); b = W'($urandom); in_valid = 1'($urandom);
      @(negedge clk);
      check("bp_sum", sum, last_e.sum);
      check("bp_cout", cout, last_e.cout);
      check("bp_ovf", overflow, last_e.ovf);
      check("bp_in_ready", in_ready, 32'd0);
      check("bp_out_valid", out_valid, 32'd1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_in_ready", in_ready, 32'd1);
    do_op(16'h8000, 16'h8000, 1'b0, c1);
    wait_done();

    // Back-to-back at minimum spacing.
    do_op(W'($urandom), W'($urandom), 1'($urandom), c1);
    do_op(W'($urandom), W'($urandom), 1'($urandom), c2);
    check("min_spacing", c2 - c1, W + 2);

    for (int i = 0; i < 20; i++) begin
      do_op(W'($urandom), W'($urandom), 1'($urandom), c1);
      repeat ($urandom_range(0, W + 4)) @(negedge clk);
    end

    n = 0;
    while ((q.size() != 0 || out_valid) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain", q.size(), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/serial_adder_16.md
SERIAL_ADDER_16 -- requirements
Module: serial_adder_16

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the operand and result width in bits; legal values are WIDTH >= 2.
REQ-002 The block SHALL have one clock, and its reset SHALL be asynchronous and active-low.
REQ-003 Port: Clk  input  1  rising-edge clock for all state.
REQ-004 Port: Rst_n  input  1  asynchronous active-low reset.
REQ-005 Port: In_Valid  input  1  operand set present on A/B/Cin.
REQ-006 Port: In_Ready  output  1  block can accept an operand set.
REQ-007 Port: A  input  WIDTH  addend, unsigned or two's complement.
REQ-008 Port: B  input  WIDTH  addend, unsigned or two's complement.
REQ-009 Port: Cin  input  1  carry into bit 0.
REQ-010 Port: Out_Valid  output  1  result on Sum/Cout/Overflow is valid.
REQ-011 Port: Out_Ready  input  1  consumer accepts the result.
REQ-012 Port: Sum  output  WIDTH  registered result (A+B+Cin) mod 2^WIDTH.
REQ-013 Port: Cout  output  1  registered carry out of bit WIDTH-1.
REQ-014 Port: Overflow  output  1  registered signed overflow.

Function
REQ-015 The block SHALL be a bit-serial adder: exactly one one-bit full-add per clock, LSB first, with the carry held in a flop between bits.
REQ-016 The FSM SHALL have states IDLE, ADD and DONE, and SHALL reset to IDLE.
REQ-017 In_Ready SHALL be 1 only in IDLE; Out_Valid SHALL be 1 only in DONE; both SHALL be decoded from state.
REQ-018 IDLE->ADD SHALL occur on the edge where In_Valid=1 and In_Ready=1 (the accept edge); that edge SHALL capture A, B and Cin into internal shift/carry registers and clear the bit counter.
REQ-019 In ADD, each edge SHALL add the current LSBs of the A/B shift registers and the carry flop, shift the sum bit into the result accumulator, update the carry flop, shift A/B right, and increment the counter.
REQ-020 ADD->DONE SHALL occur on the edge that processes bit WIDTH-1, i.e. the WIDTH-th edge after the accept edge; Out_Valid SHALL be visible WIDTH cycles after the accept edge.
REQ-021 Sum, Cout and Overflow SHALL update only on the ADD->DONE edge, and SHALL hold their value in every other cycle, including through IDLE until the next result.
REQ-022 Overflow SHALL equal (carry into bit WIDTH-1) XOR Cout.
REQ-023 DONE->IDLE SHALL occur on the edge where Out_Ready=1; while Out_Ready=0, state and all outputs SHALL hold.
REQ-024 Changes on A/B/Cin, or any In_Valid assertion, outside the accept edge SHALL have no effect on an operation in progress or on a held result.
REQ-025 No new operation SHALL be accepted in the same cycle as the output handshake; minimum spacing between operations SHALL be WIDTH+2 cycles.
REQ-026 Arithmetic SHALL wrap modulo 2^WIDTH, with no saturation.
REQ-027 The bit counter SHALL be ceil(log2(WIDTH)) bits wide and SHALL NOT wrap during an operation.

Reset
REQ-028 Rst_n=0 SHALL immediately, without waiting for a clock edge, force state=IDLE, counter=0, carry flop=0, shift registers=0, Sum=0, Cout=0 and Overflow=0; this gives In_Ready=1 and Out_Valid=0.
REQ-029 Reset asserted during ADD or DONE SHALL discard the partial or held result with no residual effect on the next operation.
REQ-030 After Rst_n deasserts, the first rising Clk edge SHALL be able to serve as an accept edge.

Verification
REQ-031 Reset then idle: pulse Rst_n low mid-cycle -> In_Ready=1, Out_Valid=0, Sum=16'h0000, Cout=0, Overflow=0 with no clock edge needed.
REQ-032 A=16'h1234, B=16'h4321, Cin=0 -> Out_Valid rises exactly 16 cycles after the accept edge; Sum=16'h5555, Cout=0, Overflow=0.
REQ-033 A=16'hFFFF, B=16'h0001, Cin=0 -> Sum=16'h0000, Cout=1, Overflow=0; separately, A=16'h7FFF, B=16'h0000, Cin=1 -> Sum=16'h8000, Cout=0, Overflow=1.
REQ-034 Backpressure: hold Out_Ready=0 for 5 cycles in DONE while toggling A/B/In_Valid -> Sum/Cout/Overflow stable and In_Ready=0 throughout; raise Out_Ready -> In_Ready=1 on the next cycle, and the next op (A=16'h8000, B=16'h8000) gives Sum=16'h0000, Cout=1, Overflow=1.
REQ-035 Reset mid-operation: assert Rst_n=0 during ADD bit 7 -> immediate IDLE with outputs 0; the following op A=16'h00FF, B=16'h0001, Cin=1 -> Sum=16'h0101, Cout=0, Overflow=0.
REQ-036 Back-to-back: two ops issued at the minimum spacing of WIDTH+2 cycles -> both results correct, and each Out_Valid lasts exactly one cycle when Out_Ready is tied to 1.
